btn_gesture_decoder: RTL and testbench



---
 rtl/btn_gesture_decoder.sv | 89 ++++++++
 tb/tb_btn_gesture_decoder.sv | 113 +++++++++++
 2 files changed

// File: rtl/btn_gesture_decoder.sv
// btn_gesture_decoder: classifies press/release pulses into short, long and double-click gestures.
// GESTURE_DOUBLE_EN enables the double-click path (WAIT2/DRAIN); otherwise a release yields o_short at once.
module btn_gesture_decoder #(
  parameter int LONG_CYCLES       = 100_000_000,
  parameter int DOUBLE_GAP_CYCLES = 30_000_000,
  parameter int CNT_W             = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ondn,
  input  logic i_onup,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_held,
  output logic o_busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, DRAIN, LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  if (LONG_CYCLES < 2 || DOUBLE_GAP_CYCLES < 2 || (LONG_CYCLES >> CNT_W) != 0 ||
      (DOUBLE_GAP_CYCLES >> CNT_W) != 0) begin : g_param_check
    $error("btn_gesture_decoder: invalid LONG_CYCLES/DOUBLE_GAP_CYCLES/CNT_W");
  end
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic short_q, short_d, long_q, long_d, double_q, double_d, held_q, held_d, busy_q, busy_d;
  logic dn, up, long_hit;
  // simultaneous press and release is a protocol violation; drop both
  assign dn = i_ondn & ~i_onup;
  assign up = i_onup & ~i_ondn;
  assign long_hit = cnt_q == LONG_M1;
`ifdef GESTURE_DOUBLE_EN
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  logic gap_hit;
  assign gap_hit = cnt_q == GAP_M1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
      busy_q   <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (dn) state_d = PRESS1;
`ifdef GESTURE_DOUBLE_EN
      PRESS1: state_d = up ? WAIT2 : long_hit ? LONG : PRESS1;
      WAIT2:  state_d = dn ? DRAIN : gap_hit ? IDLE : WAIT2;
      DRAIN:  if (up) state_d = IDLE;
`else
      PRESS1: state_d = up ? IDLE : long_hit ? LONG : PRESS1;
`endif
      LONG:   if (up) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d    = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
`ifdef GESTURE_DOUBLE_EN
    short_d  = state_q == WAIT2 && !dn && gap_hit;
    double_d = state_q == WAIT2 && dn;
`else
    short_d  = state_q == PRESS1 && up;
    double_d = 1'b0;
`endif
    long_d   = state_q == PRESS1 && !up && long_hit;
    held_d   = state_d == LONG;
    busy_d   = state_d != IDLE;
  end
  assign o_short  = short_q;
  assign o_long   = long_q;
  assign o_double = double_q;
  assign o_held   = held_q;
  assign o_busy   = busy_q;
endmodule

// File: tb/tb_btn_gesture_decoder.sv
// tb_btn_gesture_decoder: gesture vectors with a pulse scoreboard, plus a reset-mid-LONG sequence.
module tb_btn_gesture_decoder;
  localparam int S = 0, L = 1, D = 2;
  logic clk = 1'b0, rst_n = 1'b0, i_ondn = 1'b0, i_onup = 1'b0;
  logic o_short, o_long, o_double, o_held, o_busy;
  int checks = 0, errors = 0, held_bad;
  typedef struct {int d0, d1, u0, u1, b, e0, k0, e1, k1, hon, hoff, boff;} vec_t;
  typedef struct {int ed; int kind;} exp_t;
  vec_t tv[9];
  exp_t sb[$];
  always #5 clk = ~clk;
  btn_gesture_decoder #(.LONG_CYCLES(20), .DOUBLE_GAP_CYCLES(10), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_ondn(i_ondn), .i_onup(i_onup),
    .o_short(o_short), .o_long(o_long), .o_double(o_double), .o_held(o_held), .o_busy(o_busy)
  );
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic step(input bit dn, input bit up);
    @(negedge clk);
    i_ondn = dn;
    i_onup = up;
    @(posedge clk);
    #1;
  endtask
  task automatic mon(input int v, input int t, input int hon, input int hoff, input int boff);
    logic [2:0] p;
    exp_t e;
    p = {o_double, o_long, o_short};
    for (int k = 0; k < 3; k++) if (p[k]) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pulse v%0d: got kind %0d at edge %0d, want none", v, k, t);
      end else begin
        e = sb.pop_front();
        if (e.ed != t || e.kind != k) begin
          errors++;
          $display("FAIL pulse v%0d: got kind %0d at edge %0d, want kind %0d at edge %0d", v, k, t, e.kind, e.ed);
        end
      end
    end
    if (o_held !== (t >= hon && t < hoff)) held_bad++;
    if (t == boff - 1) chk($sformatf("busy_hi v%0d", v), int'(o_busy), 1);
    if (t == boff) chk($sformatf("busy_lo v%0d", v), int'(o_busy), 0);
  endtask
  initial begin
`ifdef GESTURE_DOUBLE_EN
    tv[0] = '{0, -1, 5, -1, -1, 15, S, -1, 0, -1, -1, 15};
    tv[1] = '{0, -1, 40, -1, -1, 20, L, -1, 0, 20, 40, 40};
    tv[2] = '{0, 12, 5, 30, -1, 12, D, -1, 0, -1, -1, 30};
    tv[3] = '{0, -1, 20, -1, -1, 30, S, -1, 0, -1, -1, 30};
    tv[4] = '{0, 15, 5, 18, -1, 15, D, -1, 0, -1, -1, 18};
    tv[5] = '{0, -1, 5, -1, 3, 15, S, -1, 0, -1, -1, 15};
    tv[6] = '{2, -1, 0, 4, -1, 14, S, -1, 0, -1, -1, 14};
    tv[7] = '{0, -1, 19, -1, -1, 29, S, -1, 0, -1, -1, 29};
`else
    tv[0] = '{0, -1, 5, -1, -1, 5, S, -1, 0, -1, -1, 5};
    tv[1] = '{0, -1, 40, -1, -1, 20, L, -1, 0, 20, 40, 40};
    tv[2] = '{0, 12, 5, 30, -1, 5, S, 30, S, -1, -1, 30};
    tv[3] = '{0, -1, 20, -1, -1, 20, S, -1, 0, -1, -1, 20};
    tv[4] = '{0, 15, 5, 18, -1, 5, S, 18, S, -1, -1, 18};
    tv[5] = '{0, -1, 5, -1, 3, 5, S, -1, 0, -1, -1, 5};
    tv[6] = '{2, -1, 0, 4, -1, 4, S, -1, 0, -1, -1, 4};
    tv[7] = '{0, -1, 19, -1, -1, 19, S, -1, 0, -1, -1, 19};
`endif
    tv[8] = '{0, -1, 21, -1, -1, 20, L, -1, 0, 20, 21, 21};
    #1 chk("reset_outs", int'({o_short, o_long, o_double, o_held, o_busy}), 0);
    for (int v = 0; v < 9; v++) begin
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      sb.delete();
      held_bad = 0;
      if (tv[v].e0 >= 0) sb.push_back('{tv[v].e0, tv[v].k0});
      if (tv[v].e1 >= 0) sb.push_back('{tv[v].e1, tv[v].k1});
      for (int t = 0; t < 50; t++) begin
        step(t == tv[v].d0 || t == tv[v].d1 || t == tv[v].b, t == tv[v].u0 || t == tv[v].u1 || t == tv[v].b);
        mon(v, t, tv[v].hon, tv[v].hoff, tv[v].boff);
      end
      chk($sformatf("missing_pulses v%0d", v), sb.size(), 0);
      chk($sformatf("held v%0d", v), held_bad, 0);
    end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sb.delete();
    sb.push_back('{20, L});
    held_bad = 0;
    for (int t = 0; t < 25; t++) begin
      step(t == 0, 1'b0);
      mon(90, t, 20, 1000, 1000);
    end
    chk("held_before_rst", held_bad, 0);
    chk("long_before_rst", sb.size(), 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_held", int'(o_held), 0);
    chk("rst_async_busy", int'(o_busy), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    held_bad = 0;
    for (int t = 27; t < 45; t++) begin
      step(1'b0, t == 30);
      mon(91, t, -1, -1, 1000);
      if (o_busy !== 1'b0) held_bad++;
    end
    chk("post_rst_idle", held_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
